decode_writeback: RTL and testbench
===================================

# decode_writeback

Y86-64 decode and write-back stage for the sequential (SEQ) processor. It takes the fetched `icode`/`rA`/`rB` and decodes the source and destination register IDs. It holds the 15-entry 64-bit program register file, returns `valA`/`valB` combinationally, and commits `valE`/`valM` on the rising clock edge that ends the instruction cycle. It sits directly downstream of fetch and feeds execute and memory.

## Interface
- `REG_W`, default 64: register data width.
- `NREG`, default 15: number of architectural registers, IDs 0..14. ID 15 (`RNONE`) means no register.
- `RSP_ID`, default 4: register ID of `%rsp`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en`  in  1  write-back enable. 0 when the core is halted or stalled.
- `icode`  in  4  instruction code from fetch.
- `rA`  in  4  register specifier A from fetch.
- `rB`  in  4  register specifier B from fetch.
- `cnd`  in  1  condition result from execute. Gates the `cmovXX` write.
- `valE`  in  REG_W  execute result to write back.
- `valM`  in  REG_W  memory read data to write back.
- `srcA`  out  4  decoded source A ID.
- `srcB`  out  4  decoded source B ID.
- `dstE`  out  4  decoded E destination ID, after the `cnd` gating.
- `dstM`  out  4  decoded M destination ID.
- `valA`  out  REG_W  value of `R[srcA]`; 0 if `srcA` = 15.
- `valB`  out  REG_W  value of `R[srcB]`; 0 if `srcB` = 15.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  REG_W  `R[dbg_addr]`; 0 if `dbg_addr` = 15.

## Operation
- Decode is purely combinational from `icode`, `rA`, `rB`, `cnd`.
  - `srcA`:
    - `rA` for `rrmovq`/`cmovXX` (2), `rmmovq` (4), `OPq` (6), `pushq` (A).
    - `RSP_ID` for `popq` (B), `ret` (9).
    - Otherwise 15.
  - `srcB`:
    - `rB` for 4, 5, 6.
    - `RSP_ID` for `call` (8), 9, A, B.
    - Otherwise 15.
  - `dstE`:
    - `rB` for 2 only when `cnd` = 1 (15 when `cnd` = 0).
    - `rB` for `irmovq` (3) and 6.
    - `RSP_ID` for 8, 9, A, B.
    - Otherwise 15.
  - `dstM`:
    - `rA` for `mrmovq` (5) and B.
    - Otherwise 15.
  - `icode` 0, 1, 7 and the invalid codes C..F decode all four IDs to 15.
- Register file: 15 × REG_W flops. There is no storage for ID 15.
- Write-back happens on the rising edge when `wb_en` = 1 and `rst` = 0:
  - If `dstE` ≠ 15: `R[dstE]` ← `valE`.
  - If `dstM` ≠ 15: `R[dstM]` ← `valM`.
  - If `dstE` = `dstM` ≠ 15: `valM` wins. This covers `popq %rsp`, where the final `%rsp` is the popped value.
- `wb_en` = 0: no register changes. Decode outputs stay valid.
- Writes to ID 15 are discarded silently.

## Timing
- Reads are combinational, with zero-cycle latency from the ID inputs and register state.
- A write lands at edge N. Reads during the cycle before edge N return the old value; there is no write-to-read bypass. New values are visible immediately after edge N.
- Reset:
  - `rst` = 1 at a rising edge clears all 15 registers to 0, regardless of `wb_en` or pending writes; reset wins over write-back.
  - After reset, `valA`, `valB` and `dbg_data` are 0 for every ID. Decode outputs are not registered and always follow their inputs.
- Reset asserted mid-program takes effect at the next edge only. Between the assertion and that edge, reads still return the pre-reset contents.
- Both writes to distinct registers in the same edge are applied together.

## Test plan
- Reset: run `irmovq` writes, then hold `rst` for one edge → `dbg_data` = 0 for IDs 0..14; `valA`/`valB` = 0.
- `irmovq` (icode 3, rA = F, rB = 2), `valE` = 0x1234, `wb_en` = 1, one edge → `dstE` = 2, `srcA` = `srcB` = 15 before the edge; `R[2]` = 0x1234 after the edge; the other registers are unchanged.
- `cmovXX` (icode 2, rA = 2, rB = 3), `valE` = 0x1234:
  - `cnd` = 0 → `dstE` = 15 and `R[3]` stays 0.
  - Repeat with `cnd` = 1 → `R[3]` = 0x1234.
- `popq %rsp` (icode B, rA = 4), `valE` = 0x108, `valM` = 0xBEEF, one edge → `R[4]` = 0xBEEF, not 0x108.
- `mrmovq` (icode 5, rA = 1, rB = 4), `valE` = 0x10, `valM` = 0xAA → `srcB` = 4; `dstM` = 1, `dstE` = 15; after the edge `R[1]` = 0xAA.
- `wb_en` = 0 with `OPq` (icode 6, rB = 5), `valE` = 0x77 → `R[5]` unchanged after the edge. Reads of `srcA`/`srcB` during the same cycle show the pre-edge values.

Source files
------------

// File: rtl/decode_writeback.sv
// decode_writeback
//   Y86-64 SEQ decode and write-back stage. It decodes source and destination
//   register IDs from icode/rA/rB/cnd, holds the 15 x REG_W program register
//   file, provides combinational reads, and commits valE/valM on the rising
//   clock edge.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (clears all registers)
//   wb_en               write-back enable
//   icode, rA, rB       fetched instruction fields
//   cnd                 condition flag from execute; gates the cmovXX write
//   valE, valM          write-back data (E port, M port)
//   srcA, srcB          decoded source IDs
//   dstE, dstM          decoded destination IDs (dstE already gated by cnd)
//   valA, valB          R[srcA], R[srcB]; 0 for ID 15
//   dbg_addr, dbg_data  debug read port; 0 for ID 15
`timescale 1ns/1ps
module decode_writeback #(
    parameter int REG_W  = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [REG_W-1:0] valE,
    input  logic [REG_W-1:0] valM,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [REG_W-1:0] valA,
    output logic [REG_W-1:0] valB,
    input  logic [3:0]       dbg_addr,
    output logic [REG_W-1:0] dbg_data
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_ID);

    logic [REG_W-1:0] regs [NREG];

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Per-register write select: the M port is tested first so it wins when
    // both destinations name the same register (popq %rsp). ID 15 matches no
    // entry, so writes to it are dropped without an out-of-range index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (dstM == 4'(i))      regs[i] <= valM;
                else if (dstE == 4'(i)) regs[i] <= valE;
            end
        end
    end

    always_comb begin
        valA     = '0;
        valB     = '0;
        dbg_data = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (srcA == 4'(i))     valA     = regs[i];
            if (srcB == 4'(i))     valB     = regs[i];
            if (dbg_addr == 4'(i)) dbg_data = regs[i];
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
`timescale 1ns/1ps
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst, wb_en, cnd;
    logic [3:0]  icode, rA, rB, dbg_addr;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, dbg_data;

    decode_writeback #(.REG_W(64), .NREG(15), .RSP_ID(4)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .valA(valA), .valB(valB),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [15];
    bit          model_valid = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference decode: returns {srcA, srcB, dstE, dstM}.
    function automatic logic [15:0] ref_decode(input logic [3:0] ic, input logic [3:0] a,
                                               input logic [3:0] b, input logic c);
        logic [3:0] sa, sbb, de, dm;
        sa = 4'hF; sbb = 4'hF; de = 4'hF; dm = 4'hF;
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) sa = a;
        if (ic == 4'h9 || ic == 4'hB) sa = 4'd4;
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) sbb = b;
        if (ic >= 4'h8 && ic <= 4'hB) sbb = 4'd4;
        if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) de = b;
        if (ic >= 4'h8 && ic <= 4'hB) de = 4'd4;
        if (ic == 4'h5 || ic == 4'hB) dm = a;
        return {sa, sbb, de, dm};
    endfunction

    function automatic logic [63:0] model_rd(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : model[id];
    endfunction

    // Drive one instruction cycle starting just after a falling edge: check
    // decode and pre-edge reads, push expected post-edge register state,
    // then pop and compare it through the debug port after the edge.
    task automatic do_cycle(input logic r, input logic we, input logic [3:0] ic,
                            input logic [3:0] a, input logic [3:0] b, input logic c,
                            input logic [63:0] ve, input logic [63:0] vm);
        logic [15:0] d;
        exp_t        e;
        rst = r; wb_en = we; icode = ic; rA = a; rB = b; cnd = c; valE = ve; valM = vm;
        #1;
        d = ref_decode(ic, a, b, c);
        check("srcA", {60'd0, srcA}, {60'd0, d[15:12]});
        check("srcB", {60'd0, srcB}, {60'd0, d[11:8]});
        check("dstE", {60'd0, dstE}, {60'd0, d[7:4]});
        check("dstM", {60'd0, dstM}, {60'd0, d[3:0]});
        if (model_valid) begin
            check("valA", valA, model_rd(d[15:12]));
            check("valB", valB, model_rd(d[11:8]));
        end
        if (r) begin
            for (int i = 0; i < 15; i++) model[i] = 64'd0;
            model_valid = 1;
        end else if (we && model_valid) begin
            if (d[7:4] != 4'hF) model[d[7:4]] = ve;
            if (d[3:0] != 4'hF) model[d[3:0]] = vm;
        end
        if (model_valid) begin
            for (int i = 0; i < 16; i++) begin
                e.id  = 4'(i);
                e.val = model_rd(4'(i));
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_addr = e.id;
            #1;
            check($sformatf("R[%0d]", e.id), dbg_data, e.val);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; wb_en = 0; icode = 0; rA = 4'hF; rB = 4'hF; cnd = 0;
        valE = 0; valM = 0; dbg_addr = 0;
        @(negedge clk);
        do_cycle(1, 0, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0);
        // Populate, then reset with a write pending: reset must win.
        do_cycle(0, 1, 4'h3, 4'hF, 4'h7, 0, 64'h5555, 64'h0);
        do_cycle(0, 1, 4'h3, 4'hF, 4'hE, 0, 64'h6666, 64'h0);
        do_cycle(1, 1, 4'h3, 4'hF, 4'h7, 0, 64'h9999, 64'h0);
        // irmovq to R2
        do_cycle(0, 1, 4'h3, 4'hF, 4'h2, 0, 64'h1234, 64'h0);
        // cmov, not taken then taken
        do_cycle(0, 1, 4'h2, 4'h2, 4'h3, 0, 64'h1234, 64'h0);
        do_cycle(0, 1, 4'h2, 4'h2, 4'h3, 1, 64'h1234, 64'h0);
        // popq %rsp: valM wins
        do_cycle(0, 1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'hBEEF);
        // mrmovq R1 <- M
        do_cycle(0, 1, 4'h5, 4'h1, 4'h4, 0, 64'h10, 64'hAA);
        // OPq with wb_en = 0
        do_cycle(0, 0, 4'h6, 4'h1, 4'h5, 0, 64'h77, 64'h0);
        // popq %rdi: two distinct writes in one edge
        do_cycle(0, 1, 4'hB, 4'h7, 4'hF, 0, 64'h110, 64'hCAFE);
        // call / push / ret on %rsp
        do_cycle(0, 1, 4'h8, 4'hF, 4'hF, 0, 64'h100, 64'h0);
        do_cycle(0, 1, 4'hA, 4'h7, 4'hF, 0, 64'hF8, 64'h0);
        do_cycle(0, 1, 4'h9, 4'hF, 4'hF, 0, 64'h108, 64'h4242);
        // Invalid icode and jXX: no writes
        do_cycle(0, 1, 4'hD, 4'h3, 4'h3, 1, 64'hDEAD, 64'hDEAD);
        do_cycle(0, 1, 4'h7, 4'h3, 4'h3, 1, 64'hDEAD, 64'hDEAD);
        // Random instructions
        for (int n = 0; n < 40; n++) begin
            do_cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     {$urandom, $urandom}, {$urandom, $urandom});
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
